vanilla_dmem_arbiter: RTL

- Shares the tile's single-port, synchronous-read DMEM between two requesters: the vanilla core's local load/store port and the network RX remote-DMEM port.
- The core has priority by default. A starvation counter guarantees the remote requester a grant within a bounded number of cycles.
- The block tracks the owner of each read issued and steers the 1-cycle-latency read data back to that owner with a valid strobe.

---
 rtl/vanilla_dmem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/vanilla_dmem_arbiter.sv
// Arbitrates the tile's single-port DMEM between the core and the remote (network RX) port.
// Core wins by default; a starvation counter bounds how long a valid remote request can wait.
module vanilla_dmem_arbiter #(
    parameter  int data_width_p        = 32,
    parameter  int dmem_size_p         = 1024,
    parameter  int starve_limit_p      = 4,
    localparam int dmem_addr_width_lp  = (dmem_size_p > 1) ? $clog2(dmem_size_p) : 1,
    localparam int data_mask_width_lp  = data_width_p >> 3,
    localparam int starve_cnt_width_lp = (starve_limit_p + 1 > 1) ? $clog2(starve_limit_p + 1) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic                           core_v_i,
    input  logic                           core_w_i,
    input  logic [dmem_addr_width_lp-1:0]  core_addr_i,
    input  logic [data_width_p-1:0]        core_data_i,
    input  logic [data_mask_width_lp-1:0]  core_mask_i,
    output logic                           core_yumi_o,
    output logic                           core_rdata_v_o,
    output logic [data_width_p-1:0]        core_rdata_o,

    input  logic                           remote_v_i,
    input  logic                           remote_w_i,
    input  logic [dmem_addr_width_lp-1:0]  remote_addr_i,
    input  logic [data_width_p-1:0]        remote_data_i,
    input  logic [data_mask_width_lp-1:0]  remote_mask_i,
    output logic                           remote_yumi_o,
    output logic                           remote_rdata_v_o,
    output logic [data_width_p-1:0]        remote_rdata_o,

    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [dmem_addr_width_lp-1:0]  mem_addr_o,
    output logic [data_width_p-1:0]        mem_data_o,
    output logic [data_mask_width_lp-1:0]  mem_mask_o,
    input  logic [data_width_p-1:0]        mem_data_i,

    output logic [1:0]                     dbg_rd_owner_o,
    output logic [starve_cnt_width_lp-1:0] dbg_starve_cnt_o
);

    // Handshake: a request is taken when v && yumi in the same cycle; yumi never waits on
    // anything but the other requester, and read data returns exactly one cycle later with no
    // backpressure (rdata_v is a one-cycle strobe the owner must consume).

    typedef enum logic [1:0] {
        OWNER_NONE   = 2'd0,
        OWNER_CORE   = 2'd1,
        OWNER_REMOTE = 2'd2
    } owner_e;

    localparam logic [starve_cnt_width_lp-1:0] starve_limit_lp = starve_limit_p[starve_cnt_width_lp-1:0];

    owner_e                         r_rd_owner;
    owner_e                         w_rd_owner_next;
    logic [starve_cnt_width_lp-1:0] r_starve_cnt;
    logic [starve_cnt_width_lp-1:0] w_starve_cnt_next;
    logic                           w_force_remote;
    logic                           w_grant_remote;
    logic                           w_grant_core;

    // Grants are gated by reset so nothing reaches DMEM while the tile is held in reset.
    assign w_force_remote = remote_v_i & (r_starve_cnt == starve_limit_lp);
    assign w_grant_remote = reset_n_i & remote_v_i & (w_force_remote | ~core_v_i);
    assign w_grant_core   = reset_n_i & core_v_i & ~w_grant_remote;

    assign core_yumi_o   = w_grant_core;
    assign remote_yumi_o = w_grant_remote;

    assign mem_v_o    = w_grant_core | w_grant_remote;
    assign mem_w_o    = w_grant_remote ? remote_w_i : (w_grant_core & core_w_i);
    assign mem_addr_o = w_grant_remote ? remote_addr_i : core_addr_i;
    assign mem_data_o = w_grant_remote ? remote_data_i : core_data_i;
    assign mem_mask_o = w_grant_remote ? remote_mask_i : core_mask_i;

    assign core_rdata_v_o   = reset_n_i & (r_rd_owner == OWNER_CORE);
    assign remote_rdata_v_o = reset_n_i & (r_rd_owner == OWNER_REMOTE);
    assign core_rdata_o     = mem_data_i;
    assign remote_rdata_o   = mem_data_i;

    assign dbg_rd_owner_o   = r_rd_owner;
    assign dbg_starve_cnt_o = r_starve_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_owner   <= OWNER_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_rd_owner   <= w_rd_owner_next;
            r_starve_cnt <= w_starve_cnt_next;
        end
    end

    always_comb begin
        w_rd_owner_next   = OWNER_NONE;
        w_starve_cnt_next = r_starve_cnt;
        if (w_grant_core && !core_w_i) begin
            w_rd_owner_next = OWNER_CORE;
        end else if (w_grant_remote && !remote_w_i) begin
            w_rd_owner_next = OWNER_REMOTE;
        end
        // A dropped remote request forfeits its accumulated waiting time.
        if (w_grant_remote || !remote_v_i) begin
            w_starve_cnt_next = '0;
        end else if (w_grant_core) begin
            w_starve_cnt_next = r_starve_cnt + starve_cnt_width_lp'(1);
        end
    end

endmodule
